// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: event ticks, processor handshake and status between the system and irq_arbiter
interface irq_arbiter_if #(parameter int N_SRC = 4);
  logic [N_SRC-1:0] tick;
  logic             int_ack;
  logic             isr_done;
  logic             ovf_clr;
  logic             interrupt;
  logic [2:0]       src_id;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] overflow;
  logic             busy;
  modport master (output tick, int_ack, isr_done, ovf_clr,
                  input interrupt, src_id, pending, overflow, busy);
  modport slave (input tick, int_ack, isr_done, ovf_clr,
                 output interrupt, src_id, pending, overflow, busy);
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: latches event ticks as pending and serves them one at a time over a single interrupt line
module irq_arbiter #(
  parameter int N_SRC = 4,
  parameter bit RR    = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  irq_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
  state_e           state_q, state_d;
  logic [2:0]       src_q, src_d, rr_q, rr_d, base, off, win;
  logic [3:0]       sum;
  logic             int_q, int_d;
  logic [N_SRC-1:0] pend_q, pend_d, ovf_q, ovf_d, clr_vec, rot;
  logic [2*N_SRC-1:0] dbl;
  // Rotate pending so the search always starts at bit 0, then map back to a source index
  always_comb begin
    base = RR ? rr_q : 3'd0;
    dbl  = {pend_q, pend_q} >> base;
    rot  = dbl[N_SRC-1:0];
    off  = '0;
    for (int k = N_SRC - 1; k >= 0; k--) off = rot[k] ? 3'(k) : off;
    sum  = {1'b0, base} + {1'b0, off};
    win  = 3'(sum >= 4'(N_SRC) ? sum - 4'(N_SRC) : sum);
  end
  always_comb begin
    clr_vec = (state_q == REQ && bus.int_ack) ? N_SRC'(1) << src_q : '0;
    pend_d  = (pend_q & ~clr_vec) | bus.tick;
    ovf_d   = (bus.ovf_clr ? '0 : ovf_q) | (bus.tick & pend_q & ~clr_vec);
  end
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rr_d    = rr_q;
    int_d   = int_q;
    case (state_q)
      IDLE: if (|pend_q) begin
        src_d   = win;
        int_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (bus.int_ack) begin
        int_d   = 1'b0;
        state_d = SERVICE;
      end
      SERVICE: if (bus.isr_done) begin
        state_d = IDLE;
        rr_d    = RR ? (src_q == 3'(N_SRC - 1) ? 3'd0 : src_q + 3'd1) : rr_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      rr_q    <= '0;
      int_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      int_q   <= int_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.interrupt = int_q;
  assign bus.src_id    = src_q;
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: round-robin and fixed-priority arbiters share one stimulus, checked against a queue-free event model
module tb_irq_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] tick = '0;
  logic ack = 1'b0, done = 1'b0, oclr = 1'b0;
  int tests = 0, errors = 0;
  irq_arbiter_if #(.N_SRC(N)) b0 ();
  irq_arbiter_if #(.N_SRC(N)) b1 ();
  assign b0.tick = tick;
  assign b0.int_ack = ack;
  assign b0.isr_done = done;
  assign b0.ovf_clr = oclr;
  assign b1.tick = tick;
  assign b1.int_ack = ack;
  assign b1.isr_done = done;
  assign b1.ovf_clr = oclr;
  irq_arbiter #(.N_SRC(N), .RR(1'b1)) u_rr (.clk(clk), .reset(reset), .bus(b0));
  irq_arbiter #(.N_SRC(N), .RR(1'b0)) u_fp (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  // model: phase 0 waiting, 1 requesting, 2 in ISR
  int m_ph[2], m_src[2], m_ptr[2];
  bit m_pend[2][N], m_ovf[2][N];
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int vec(input int m, input bit ovf);
    int v = 0;
    for (int i = 0; i < N; i++) if (ovf ? m_ovf[m][i] : m_pend[m][i]) v += 1 << i;
    return v;
  endfunction
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int served = (m_ph[m] == 1 && ack) ? m_src[m] : -1;
      bit was[N];
      for (int i = 0; i < N; i++) was[i] = m_pend[m][i];
      if (reset) begin
        m_ph[m] = 0; m_src[m] = 0; m_ptr[m] = 0;
        for (int i = 0; i < N; i++) begin m_pend[m][i] = 0; m_ovf[m][i] = 0; end
        continue;
      end
      for (int i = 0; i < N; i++) begin
        bit kept = was[i] && i != served;
        m_ovf[m][i] = (m_ovf[m][i] && !oclr) || (tick[i] && kept);
        m_pend[m][i] = kept || tick[i];
      end
      if (m_ph[m] == 0) begin
        for (int k = 0; k < N; k++) begin
          int idx = ((m == 0 ? m_ptr[m] : 0) + k) % N;
          if (was[idx]) begin m_src[m] = idx; m_ph[m] = 1; break; end
        end
      end else if (m_ph[m] == 1) begin
        if (ack) m_ph[m] = 2;
      end else if (done) begin
        m_ph[m] = 0;
        if (m == 0) m_ptr[m] = (m_src[m] + 1) % N;
      end
    end
  endtask
  task automatic check_all();
    chk("rr.interrupt", int'(b0.interrupt), int'(m_ph[0] == 1));
    chk("rr.src_id", int'(b0.src_id), m_src[0]);
    chk("rr.pending", int'(b0.pending), vec(0, 0));
    chk("rr.overflow", int'(b0.overflow), vec(0, 1));
    chk("rr.busy", int'(b0.busy), int'(m_ph[0] != 0));
    chk("fp.interrupt", int'(b1.interrupt), int'(m_ph[1] == 1));
    chk("fp.src_id", int'(b1.src_id), m_src[1]);
    chk("fp.pending", int'(b1.pending), vec(1, 0));
    chk("fp.overflow", int'(b1.overflow), vec(1, 1));
    chk("fp.busy", int'(b1.busy), int'(m_ph[1] != 0));
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    tick = '0; ack = 0; done = 0; oclr = 0; reset = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    cycle();
  endtask
  initial begin
    do_reset();
    repeat (10) cycle();
    chk("idle.interrupt", int'(b0.interrupt), 0);
    chk("idle.src_id", int'(b0.src_id), 0);
    chk("idle.busy", int'(b0.busy), 0);
    // single tick through full service
    tick = 4'b0100; cycle();
    chk("s2.pending", int'(b0.pending), 4);
    cycle();
    chk("s2.interrupt", int'(b0.interrupt), 1);
    chk("s2.src_id", int'(b0.src_id), 2);
    ack = 1; cycle();
    chk("s2.ack_irq", int'(b0.interrupt), 0);
    chk("s2.ack_pend", int'(b0.pending), 0);
    done = 1; cycle();
    chk("s2.done_busy", int'(b0.busy), 0);
    // round-robin over all four then wrap
    do_reset();
    tick = 4'b1111; cycle(); cycle();
    for (int k = 0; k < N; k++) begin
      chk("s3.order", int'(b0.src_id), k);
      ack = 1; cycle(); done = 1; cycle(); cycle();
    end
    tick = 4'b0011; cycle(); cycle();
    chk("s3.wrap0", int'(b0.src_id), 0);
    ack = 1; cycle(); done = 1; cycle(); cycle();
    chk("s3.wrap1", int'(b0.src_id), 1);
    // fixed priority re-serves source 1 before 3
    do_reset();
    tick = 4'b1010; cycle(); cycle();
    chk("s4.first", int'(b1.src_id), 1);
    ack = 1; cycle(); tick = 4'b0010; cycle(); done = 1; cycle(); cycle();
    chk("s4.second", int'(b1.src_id), 1);
    ack = 1; cycle(); done = 1; cycle(); cycle();
    chk("s4.third", int'(b1.src_id), 3);
    // overflow and tick coinciding with ack
    do_reset();
    tick = 4'b0001; cycle(); tick = 4'b0001; cycle(); tick = 4'b0001; cycle();
    chk("s5.ovf", int'(b0.overflow), 1);
    ack = 1; cycle(); done = 1; cycle(); cycle();
    chk("s5.single", int'(b0.interrupt), 0);
    oclr = 1; cycle();
    chk("s5.ovf_clr", int'(b0.overflow), 0);
    tick = 4'b0001; cycle(); cycle();
    tick = 4'b0001; ack = 1; cycle();
    chk("s5.keep", int'(b0.pending), 1);
    chk("s5.no_ovf", int'(b0.overflow), 0);
    // reset aborts a request in flight
    do_reset();
    tick = 4'b0110; cycle(); cycle();
    reset = 1; cycle();
    chk("s6.irq", int'(b0.interrupt), 0);
    chk("s6.pend", int'(b0.pending), 0);
    ack = 1; cycle();
    chk("s6.busy", int'(b0.busy), 0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) tick[i] = ($urandom_range(5) == 0);
      ack = ($urandom_range(3) == 0);
      done = ($urandom_range(3) == 0);
      oclr = ($urandom_range(19) == 0);
      reset = ($urandom_range(299) == 0);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
